fp_square: RTL and testbench



---
 rtl/fp_square.sv | 124 ++++++++++++
 tb/tb_fp_square.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_square.sv
// fp_square: sequential unsigned fixed-point squarer.
//   out = (in * in) >> FRAC_WIDTH, one multiplier bit per cycle (shift-and-add).
//   A go accepted in IDLE starts WIDTH iterations; done pulses for one cycle
//   when the result is registered. out/overflow hold until the next completion.
// Optional feature macro: FP_SQUARE_SATURATE_EN
//   defined   -> out forced to all ones whenever overflow is set
//   undefined -> out carries the wrapped value p[FRAC_WIDTH +: WIDTH]
// Handshake: go is only looked at while idle (state_dbg == 0). An edge with
//   go=1, reset=0 in IDLE accepts the operand on in; go and in are ignored
//   during RUN. done is high for exactly one cycle per accepted operation and
//   the block is already IDLE during that cycle. reset overrides go.
// state_dbg exposes the FSM state (0 = IDLE, 1 = RUN).
module fp_square #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             overflow,
  output logic             state_dbg
);

  localparam int IDX_W = $clog2(WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  // The number format must exactly fill the word.
  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_format
    $error("fp_square: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [2*WIDTH-1:0]   mc;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   p_next;
  logic [WIDTH-1:0]     mp;
  logic [IDX_W-1:0]     idx;
  logic                 accept;
  logic                 last_iter;
  logic                 p_ovf;
  logic [WIDTH-1:0]     p_wrapped;
  logic [WIDTH-1:0]     p_result;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state: IDLE -> RUN on go, RUN -> IDLE after the last iteration.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (go) state_next = S_RUN;
      S_RUN:   if (idx == LAST_IDX) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM-derived control strobes and debug view of the state.
  always_comb begin
    accept    = (state == S_IDLE) && go;
    last_iter = (state == S_RUN) && (idx == LAST_IDX);
    state_dbg = state;
  end

  // Accumulator after this cycle's conditional add, and the result derived
  // from it. The full 2*WIDTH product always fits, so nothing wraps here.
  always_comb begin
    p_next    = mp[0] ? (acc + mc) : acc;
    p_wrapped = WIDTH'(p_next >> FRAC_WIDTH);
    p_ovf     = |(p_next >> (WIDTH + FRAC_WIDTH));
`ifdef FP_SQUARE_SATURATE_EN
    p_result  = p_ovf ? {WIDTH{1'b1}} : p_wrapped;
`else
    p_result  = p_wrapped;
`endif
  end

  // Shift-and-add datapath: load on accept, iterate while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      mc  <= '0;
      mp  <= '0;
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      mc  <= {{WIDTH{1'b0}}, in};
      mp  <= in;
      acc <= '0;
      idx <= '0;
    end else if (state == S_RUN) begin
      acc <= p_next;
      mc  <= mc << 1;
      mp  <= mp >> 1;
      idx <= idx + 1'b1;
    end
  end

  // Result registers: updated only on completion; done is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      out      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last_iter;
      if (last_iter) begin
        out      <= p_result;
        overflow <= p_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_square.sv
// tb_fp_square: directed + randomized checks of fp_square against a plain
// arithmetic reference (square the operand, shift, test the high bits).
// Instance dut_a: WIDTH=32, FRAC_WIDTH=16. Instance dut_b: integer mode.
module tb_fp_square;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         go_a, go_b;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] out_a, out_b;
  logic         done_a, done_b;
  logic         ovf_a, ovf_b;
  logic         st_a, st_b;

  int n_cmp = 0;
  int n_err = 0;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  fp_square #(.WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .go(go_a), .in(in_a),
    .out(out_a), .done(done_a), .overflow(ovf_a), .state_dbg(st_a)
  );

  fp_square #(.WIDTH(32), .INT_WIDTH(32), .FRAC_WIDTH(0)) dut_b (
    .clk(clk), .reset(reset), .go(go_b), .in(in_b),
    .out(out_b), .done(done_b), .overflow(ovf_b), .state_dbg(st_b)
  );

  // Reference: exact square, truncate the fraction, flag lost high bits.
  function automatic logic [W-1:0] ref_out(input logic [W-1:0] v, input int frac);
    logic [63:0] prod;
    prod = 64'(v) * 64'(v);
`ifdef FP_SQUARE_SATURATE_EN
    if ((prod >> (W + frac)) != 0) return {W{1'b1}};
`endif
    return W'(prod >> frac);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] v, input int frac);
    logic [63:0] prod;
    prod = 64'(v) * 64'(v);
    return (prod >> (W + frac)) != 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  task automatic drive(input bit sel, input logic g, input logic [W-1:0] v);
    if (sel) begin go_b = g; in_b = v; end
    else     begin go_a = g; in_a = v; end
  endtask

  // One full operation: go for one cycle, measure latency, check result.
  task automatic do_op(input bit sel, input logic [W-1:0] v, input string tag);
    int k;
    int frac;
    frac = sel ? 0 : 16;
    @(negedge clk); drive(sel, 1'b1, v);
    @(negedge clk); drive(sel, 1'b0, $urandom);
    k = 0;
    while (!done_of(sel) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'd32);
    check({tag, "_out"}, 64'(sel ? out_b : out_a), 64'(ref_out(v, frac)));
    check({tag, "_ovf"}, 64'(sel ? ovf_b : ovf_a), 64'(ref_ovf(v, frac)));
    @(negedge clk);
    check({tag, "_done_width"}, 64'(done_of(sel)), 64'd0);
  endtask

  logic [W-1:0] dir_a[8] = '{32'h0003_0000, 32'h0000_8000, 32'h0000_0001, 32'h0100_0000,
                             32'h00FF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0001_0000};

  initial begin
    int k, n_done;
    int dk[$];
    logic [W-1:0] dout[$];
    logic [W-1:0] v;

    reset = 1'b1; go_a = 0; go_b = 0; in_a = 0; in_b = 0;
    repeat (3) @(negedge clk);
    check("reset_out", 64'(out_a), 64'd0);
    check("reset_done", 64'(done_a), 64'd0);
    check("reset_ovf", 64'(ovf_a), 64'd0);
    check("reset_state", 64'(st_a), 64'd0);
    reset = 1'b0;

    // Directed operands, including the spec's basic/fraction/overflow cases.
    foreach (dir_a[i]) do_op(1'b0, dir_a[i], $sformatf("dir%0d", i));
    // Literal expectations for the headline cases, independent of the model.
    do_op(1'b0, 32'h0003_0000, "basic");
    check("basic_lit", 64'(out_a), 64'h0009_0000);
    do_op(1'b0, 32'h0000_8000, "half");
    check("half_lit", 64'(out_a), 64'h0000_4000);
    do_op(1'b0, 32'h0100_0000, "ovf256");
    check("ovf256_flag", 64'(ovf_a), 64'd1);
`ifdef FP_SQUARE_SATURATE_EN
    check("ovf256_lit", 64'(out_a), 64'hFFFF_FFFF);
`else
    check("ovf256_lit", 64'(out_a), 64'h0000_0000);
`endif

    // Randomized operands across small, mid and full ranges.
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: v = W'($urandom_range(0, 32'h0000_FFFF));
        1: v = W'($urandom_range(0, 32'h00FF_FFFF));
        default: v = W'($urandom);
      endcase
      do_op(1'b0, v, $sformatf("rnd%0d", i));
    end

    // Back-to-back: go held high; the second operand is presented mid-run.
    @(negedge clk); go_a = 1; in_a = 32'h0002_0000;
    @(negedge clk); in_a = 32'h0005_0000;
    for (k = 0; k < 80; k++) begin
      if (done_a) begin dk.push_back(k); dout.push_back(out_a); end
      if (k == 33) go_a = 0;
      @(negedge clk);
    end
    check("b2b_count", 64'(dk.size()), 64'd2);
    if (dk.size() == 2) begin
      check("b2b_first_k", 64'(dk[0]), 64'd32);
      check("b2b_second_k", 64'(dk[1]), 64'd65);
      check("b2b_first_out", 64'(dout[0]), 64'h0004_0000);
      check("b2b_second_out", 64'(dout[1]), 64'h0019_0000);
    end

    // Busy ignore: a new go/in during RUN must not disturb the operation.
    @(negedge clk); go_a = 1; in_a = 32'h0003_0000;
    @(negedge clk); go_a = 0;
    n_done = 0;
    for (k = 0; k < 60; k++) begin
      if (k == 5) begin go_a = 1; in_a = 32'h0007_0000; end
      if (k == 6) go_a = 0;
      if (done_a) begin
        n_done++;
        check("busy_k", 64'(k), 64'd32);
        check("busy_out", 64'(out_a), 64'h0009_0000);
      end
      @(negedge clk);
    end
    check("busy_done_count", 64'(n_done), 64'd1);

    // Reset mid-run: no done for the aborted op, out reads 0 afterwards.
    @(negedge clk); go_a = 1; in_a = 32'h0011_0000;
    @(negedge clk); go_a = 0;
    n_done = 0;
    for (k = 0; k < 60; k++) begin
      if (k == 9) reset = 1;
      if (k == 10) begin
        reset = 0;
        check("rst_out", 64'(out_a), 64'd0);
        check("rst_state", 64'(st_a), 64'd0);
      end
      if (done_a) n_done++;
      @(negedge clk);
    end
    check("rst_no_done", 64'(n_done), 64'd0);
    do_op(1'b0, 32'h0004_0000, "post_rst");
    check("post_rst_lit", 64'(out_a), 64'h0010_0000);

    // Integer mode instance.
    do_op(1'b1, 32'd65535, "int_max");
    check("int_max_lit", 64'(out_b), 64'hFFFE_0001);
    do_op(1'b1, 32'd65536, "int_ovf");
    check("int_ovf_flag", 64'(ovf_b), 64'd1);
    for (int i = 0; i < 8; i++) do_op(1'b1, W'($urandom_range(0, 32'h0003_FFFF)), $sformatf("int_rnd%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
